// File: rtl/pu_net_tx.sv
// Transmit network interface: frames dmem flits, buffers them in a FIFO and forwards them to the router link.
// Define PKT_STORE_FWD_EN for store-and-forward release; the default build is cut-through.
`ifndef PKTW
`define PKTW 17
`endif
`ifndef FLOWBH
`define FLOWBH 17
`endif
`ifndef FLOWBL
`define FLOWBL 16
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module pu_net_tx #(
   parameter logic [1:0] pu_num = 2'd0,
   parameter int         DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [`PKTW:0]           tx_in,
   output logic [`PKTW:0]           link_out,
   input  logic                     link_rdy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy,
   output logic                     ovf,
   output logic                     perr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int FW = `PKTW + 1;

   typedef enum logic {ST_IDLE, ST_IN_PKT} pkt_state_e;

   pkt_state_e       in_state_q, in_state_d;
   pkt_state_e       out_state_q, out_state_d;
   logic [FW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic [FW-1:0]    link_out_q;
   logic             ovf_q, perr_q;

   logic [1:0]       in_flow, head_flow;
   logic [FW-1:0]    head;
   logic             accept, frame_err, full, push, pop, release_ok;

   logic             unused_pu;
   assign unused_pu = ^pu_num;

   assign in_flow   = tx_in[`FLOWBH:`FLOWBL];
   assign head      = mem_q[rd_ptr_q];
   assign head_flow = head[`FLOWBH:`FLOWBL];
   assign full      = (level_q == LW'(DEPTH));

   // Input framing FSM: only non-zero flits are examined.
   always_comb begin
      in_state_d = in_state_q;
      accept     = 1'b0;
      frame_err  = 1'b0;
      if (tx_in != '0) begin
         case (in_state_q)
            ST_IDLE: begin
               if (in_flow == `HEAD) begin
                  accept     = 1'b1;
                  in_state_d = ST_IN_PKT;
               end else begin
                  frame_err = 1'b1;
               end
            end
            ST_IN_PKT: begin
               if (in_flow == `BODY) begin
                  accept = 1'b1;
               end else if (in_flow == `TAIL) begin
                  accept     = 1'b1;
                  in_state_d = ST_IDLE;
               end else begin
                  frame_err = 1'b1;
               end
            end
            default: frame_err = 1'b1;
         endcase
      end
   end

`ifdef PKT_STORE_FWD_EN
   logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          tail_push, tail_pop;

   assign tail_push = push && (in_flow == `TAIL);
   assign tail_pop  = pop && (head_flow == `TAIL);

   // A full FIFO with no complete packet would never drain: fall back to cut-through.
   assign release_ok = (out_state_q == ST_IN_PKT) || (pkt_cnt_q != '0) ||
                       (full && (pkt_cnt_q == '0));

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (tail_push && !tail_pop)      pkt_cnt_d = pkt_cnt_q + LW'(1);
      else if (tail_pop && !tail_push) pkt_cnt_d = pkt_cnt_q - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) pkt_cnt_q <= '0;
      else     pkt_cnt_q <= pkt_cnt_d;
   end
`else
   assign release_ok = 1'b1;
`endif

   assign pop  = (level_q != '0) && link_rdy && release_ok;
   assign push = accept && (!full || pop);

   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
   end

   always_comb begin
      out_state_d = out_state_q;
      if (pop) begin
         if (head_flow == `HEAD)      out_state_d = ST_IN_PKT;
         else if (head_flow == `TAIL) out_state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_state_q  <= ST_IDLE;
         out_state_q <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         link_out_q  <= '0;
         ovf_q       <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         in_state_q  <= in_state_d;
         out_state_q <= out_state_d;
         level_q     <= level_d;
         link_out_q  <= pop ? head : '0;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (accept && full && !pop) ovf_q <= 1'b1;
         if (frame_err)              perr_q <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only read below the level count.
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= tx_in;
   end

   assign link_out = link_out_q;
   assign level    = level_q;
   assign busy     = (level_q != '0) || (in_state_q == ST_IN_PKT);
   assign ovf      = ovf_q;
   assign perr     = perr_q;

endmodule

// File: tb/tb_pu_net_tx.sv
// Self-checking bench for pu_net_tx: a scoreboard queue holds every flit expected on link_out.
`ifndef PKTW
`define PKTW 17
`endif
`ifndef FLOWBH
`define FLOWBH 17
`endif
`ifndef FLOWBL
`define FLOWBL 16
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module tb_pu_net_tx;
  localparam int DEPTH = 8;
  localparam int FW    = `PKTW + 1;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PKT_STORE_FWD_EN
  localparam int FIRST_LAT = 5;
  localparam int T1_PEAK   = 4;
  localparam int T6_PEAK   = DEPTH;
`else
  localparam int FIRST_LAT = 2;
  localparam int T1_PEAK   = 1;
  localparam int T6_PEAK   = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] tx_in;
  logic [FW-1:0] link_out;
  logic          link_rdy;
  logic [LW-1:0] level;
  logic          busy, ovf, perr;

  pu_net_tx #(.pu_num(2'd0), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_in    (tx_in),
    .link_out (link_out),
    .link_rdy (link_rdy),
    .level    (level),
    .busy     (busy),
    .ovf      (ovf),
    .perr     (perr)
  );

  // clock / reset support
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [FW-1:0] exp_q[$];
  int            cyc      = 0;
  logic          rdy_prev = 1'b0;
  int            n_out    = 0;

  int            lvl_max;
  int            t_n, t_first, t_last;
  logic          t_gap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_prev <= link_rdy;
  end

  // scoreboard: every emitted flit must follow a ready cycle and match the queue head
  always @(negedge clk) begin
    if (link_out != '0) begin
      n_out++;
      check("out_rdy", {31'd0, rdy_prev}, 32'd1);
      if (exp_q.size() == 0) check("out_extra", {14'd0, link_out}, 32'd0);
      else                   check("out_data", {14'd0, link_out}, {14'd0, exp_q.pop_front()});
    end
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] code, input logic [15:0] pl);
    return {code, pl};
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
    if (int'(level) > lvl_max) lvl_max = int'(level);
    if (link_out != '0) begin
      if (t_n == 0) t_first = cyc;
      else if (cyc != t_last + 1) t_gap = 1'b1;
      t_last = cyc;
      t_n++;
    end
  endtask

  task automatic send(input logic [FW-1:0] flit, input logic acc);
    tx_in = flit;
    if (acc) exp_q.push_back(flit);
    tick();
    tx_in = '0;
  endtask

  task automatic idle(input int n);
    tx_in = '0;
    repeat (n) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c0;
    rst = 1'b1; tx_in = '0; link_rdy = 1'b0;
    lvl_max = 0; t_n = 0; t_first = 0; t_last = 0; t_gap = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_link_out", {14'd0, link_out}, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_perr", {31'd0, perr}, 32'd0);
    rst = 1'b0;
    idle(1);

    // 1: basic packet, latency and back-to-back output
    link_rdy = 1'b1; lvl_max = 0; t_n = 0; t_gap = 1'b0; c0 = cyc;
    send(mk(`HEAD, 16'h0012), 1'b1);
    send(mk(`BODY, 16'hBEEF), 1'b1);
    send(mk(`BODY, 16'h00A5), 1'b1);
    send(mk(`TAIL, 16'h0000), 1'b1);
    idle(10);
    check("t1_count", t_n, 32'd4);
    check("t1_gap", {31'd0, t_gap}, 32'd0);
    check("t1_latency", t_first - c0, FIRST_LAT);
    check("t1_level_peak", lvl_max, T1_PEAK);

    // 2: overflow with link stalled, then drain
    link_rdy = 1'b0; n0 = n_out;
    send(mk(`HEAD, 16'h0100), 1'b1);
    for (int i = 0; i < DEPTH; i++) send(mk(`BODY, 16'h0200 + 16'(i)), i < DEPTH - 1);
    idle(1);
    check("t2_level_full", {28'd0, level}, DEPTH);
    check("t2_ovf", {31'd0, ovf}, 32'd1);
    check("t2_perr", {31'd0, perr}, 32'd0);
    link_rdy = 1'b1;
    idle(DEPTH + 4);
    check("t2_drained", n_out - n0, DEPTH);
    check("t2_link_idle", {14'd0, link_out}, 32'd0);
    check("t2_level_zero", {28'd0, level}, 32'd0);
    send(mk(`TAIL, 16'h02FF), 1'b1);
    idle(4);

    // 3: framing errors
    link_rdy = 1'b0;
    send(mk(`BODY, 16'h1111), 1'b0);
    send(mk(`HEAD, 16'h0001), 1'b1);
    send(mk(`HEAD, 16'h0001), 1'b0);
    idle(1);
    check("t3_perr", {31'd0, perr}, 32'd1);
    check("t3_level", {28'd0, level}, 32'd1);
    send(mk(`TAIL, 16'h0003), 1'b1);
    link_rdy = 1'b1;
    idle(6);
    check("t3_level_zero", {28'd0, level}, 32'd0);

    // 4: link_rdy toggling during a 6-flit packet
    n0 = n_out;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] code;
      code = (i == 0) ? `HEAD : ((i == 5) ? `TAIL : `BODY);
      link_rdy = (i % 2 == 0);
      send(mk(code, 16'($urandom_range(0, 16'hFFFF))), 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      link_rdy = (i % 2 == 0);
      idle(1);
    end
    link_rdy = 1'b1;
    idle(10);
    check("t4_count", n_out - n0, 32'd6);
    check("t4_queue_empty", exp_q.size(), 32'd0);

    // 5: reset mid-packet discards buffered flits
    link_rdy = 1'b0;
    send(mk(`HEAD, 16'h5000), 1'b1);
    send(mk(`BODY, 16'h5001), 1'b1);
    idle(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t5_level", {28'd0, level}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_link_out", {14'd0, link_out}, 32'd0);
    check("t5_ovf", {31'd0, ovf}, 32'd0);
    check("t5_perr_cleared", {31'd0, perr}, 32'd0);
    link_rdy = 1'b1;
    send(mk(`BODY, 16'h2222), 1'b0);
    idle(2);
    check("t5_perr_set", {31'd0, perr}, 32'd1);
    check("t5_level_after", {28'd0, level}, 32'd0);
    check("t5_busy_after", {31'd0, busy}, 32'd0);

    // 6: long packet with no TAIL in flight (forced release in store-and-forward)
    link_rdy = 1'b1; lvl_max = 0; n0 = n_out;
    send(mk(`HEAD, 16'h6000), 1'b1);
    for (int i = 0; i < DEPTH; i++) send(mk(`BODY, 16'h6100 + 16'(i)), 1'b1);
    send(mk(`TAIL, 16'h6FFF), 1'b1);
    idle(DEPTH + 8);
    check("t6_count", n_out - n0, DEPTH + 2);
    check("t6_level_peak", lvl_max, T6_PEAK);
    check("t6_ovf", {31'd0, ovf}, 32'd0);
    check("t6_level_zero", {28'd0, level}, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
